// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order pipeline.
// Handles data-memory wait stalls with a timeout, load-use stalls, and
// taken-branch flushes. Also keeps a saturating count of fetch-stall cycles.
module pipe_hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RtE,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_stats,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             err,
  output logic [15:0]      stall_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam logic [15:0] TO = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        mw, lu;

  assign mw = mem_req && !mem_ready;
  assign lu = MemtoRegE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));

  // Next-state and hazard control outputs; everything is forced low while in reset.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    StallF       = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    StallM       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    case (state)
      RUN: begin
        if (mw) begin
          {StallF, StallD, StallE, StallM} = '1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 16'd1;
        end else if (lu) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end else if (PCSrcD) begin
          FlushD = 1'b1;
        end
      end
      MEM_WAIT: begin
        // A dropped request ends the wait exactly like a ready response.
        if (mw) begin
          {StallF, StallD, StallE, StallM} = '1;
          if (wait_cnt == TO) state_nxt = ERROR;
          else                wait_cnt_nxt = wait_cnt + 16'd1;
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
          if (lu) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end else if (PCSrcD) begin
            FlushD = 1'b1;
          end
        end
      end
      ERROR: begin
        {StallF, StallD, StallE, StallM} = '1;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
    if (!reset) begin
      {StallF, StallD, StallE, StallM, FlushD, FlushE} = '0;
    end
  end

  // State and wait counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Sticky timeout flag, set on the edge that enters ERROR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  err <= 1'b0;
    else if (state_nxt == ERROR) err <= 1'b1;
  end

  // Saturating fetch-stall cycle counter; clear wins over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           stall_count <= '0;
    else if (clr_stats)                   stall_count <= '0;
    else if (StallF && stall_count != '1) stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl. A second instance with
// TIMEOUT=4 shares all inputs and is used for the timeout/ERROR scenario.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RsD, RtD, RtE;
  logic        MemtoRegE, PCSrcD, mem_req, mem_ready, clr_stats;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, err;
  logic [15:0] stall_count;
  logic        StallF4, StallD4, StallE4, StallM4, FlushD4, FlushE4, err4;
  logic [15:0] stall_count4;
  logic [5:0]  ctl, ctl4;
  logic [31:0] instr = 32'hDEADBEEF;
  logic [31:0] ifid  = 32'h12345678;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ctl  = {StallF, StallD, StallE, StallM, FlushD, FlushE};
  assign ctl4 = {StallF4, StallD4, StallE4, StallM4, FlushD4, FlushE4};

  // IF/ID register model driven by the controller outputs.
  always @(posedge clk) begin
    if (FlushD)       ifid <= 32'h0;
    else if (!StallD) ifid <= instr;
  end

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RtE(RtE),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .mem_req(mem_req),
    .mem_ready(mem_ready), .clr_stats(clr_stats),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .err(err), .stall_count(stall_count)
  );

  pipe_hazard_ctrl #(.REG_W(5), .TIMEOUT(4)) dut4 (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RtE(RtE),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .mem_req(mem_req),
    .mem_ready(mem_ready), .clr_stats(clr_stats),
    .StallF(StallF4), .StallD(StallD4), .StallE(StallE4), .StallM(StallM4),
    .FlushD(FlushD4), .FlushE(FlushE4), .err(err4), .stall_count(stall_count4)
  );

  task automatic idle();
    RsD = 5'd0; RtD = 5'd0; RtE = 5'd0;
    MemtoRegE = 1'b0; PCSrcD = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; clr_stats = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    mem_req = 1'b1; MemtoRegE = 1'b1; RtE = 5'd3; RsD = 5'd3; PCSrcD = 1'b1;
    #1;
    checks++;
    if (ctl !== 6'b000000) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b000000); end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (ctl !== 6'b000000) begin errors++; $display("FAIL reset_ctl_clk: got %b expected %b", ctl, 6'b000000); end
    checks++;
    if (err !== 1'b0 || stall_count !== 16'd0) begin
      errors++; $display("FAIL reset_regs: got err=%b cnt=%0d expected err=0 cnt=0", err, stall_count);
    end
    @(negedge clk);
    idle();
    reset = 1'b1;
  endtask

  task automatic test_load_use();
    @(posedge clk); #1;
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    @(negedge clk);
    checks++;
    if (ctl !== 6'b110001) begin errors++; $display("FAIL lu_rs_ctl: got %b expected %b", ctl, 6'b110001); end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    checks++;
    if (ctl !== 6'b000000) begin errors++; $display("FAIL lu_one_cycle: got %b expected %b", ctl, 6'b000000); end
    checks++;
    if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count: got %0d expected 1", stall_count); end
    @(posedge clk); #1;
    MemtoRegE = 1'b1; RtE = 5'd7; RtD = 5'd7; RsD = 5'd2;
    @(negedge clk);
    checks++;
    if (ctl !== 6'b110001) begin errors++; $display("FAIL lu_rt_ctl: got %b expected %b", ctl, 6'b110001); end
    @(posedge clk); #1;
    idle();
    checks++;
    if (stall_count !== 16'd2) begin errors++; $display("FAIL lu_count2: got %0d expected 2", stall_count); end
  endtask

  task automatic test_zero_reg();
    @(posedge clk); #1;
    MemtoRegE = 1'b1; RtE = 5'd0; RsD = 5'd0; RtD = 5'd0;
    @(negedge clk);
    checks++;
    if (ctl !== 6'b000000) begin errors++; $display("FAIL zero_reg_ctl: got %b expected %b", ctl, 6'b000000); end
    @(posedge clk); #1;
    MemtoRegE = 1'b1; RtE = 5'd9; RsD = 5'd8; RtD = 5'd10;
    @(negedge clk);
    checks++;
    if (ctl !== 6'b000000) begin errors++; $display("FAIL no_match_ctl: got %b expected %b", ctl, 6'b000000); end
  endtask

  task automatic test_clr_stats();
    @(posedge clk); #1;
    idle();
    MemtoRegE = 1'b1; RtE = 5'd4; RsD = 5'd4; clr_stats = 1'b1;
    @(posedge clk); #1;
    idle();
    checks++;
    if (stall_count !== 16'd0) begin errors++; $display("FAIL clr_priority: got %0d expected 0", stall_count); end
  endtask

  task automatic test_branch();
    @(posedge clk); #1;
    checks++;
    if (ifid !== 32'hDEADBEEF) begin errors++; $display("FAIL ifid_pre: got %h expected %h", ifid, 32'hDEADBEEF); end
    PCSrcD = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== 6'b000010) begin errors++; $display("FAIL branch_ctl: got %b expected %b", ctl, 6'b000010); end
    @(posedge clk); #1;
    idle();
    checks++;
    if (ifid !== 32'h0) begin errors++; $display("FAIL branch_ifid: got %h expected %h", ifid, 32'h0); end
    @(negedge clk);
    checks++;
    if (ctl !== 6'b000000) begin errors++; $display("FAIL branch_one_cycle: got %b expected %b", ctl, 6'b000000); end
  endtask

  task automatic test_branch_lu();
    @(posedge clk); #1;
    PCSrcD = 1'b1; MemtoRegE = 1'b1; RtE = 5'd6; RtD = 5'd6;
    @(negedge clk);
    checks++;
    if (ctl !== 6'b110001) begin errors++; $display("FAIL branch_lu_ctl: got %b expected %b", ctl, 6'b110001); end
    @(posedge clk); #1;
    idle();
    clr_stats = 1'b1;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_mem_wait();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== 6'b111100) begin errors++; $display("FAIL mw_stall[%0d]: got %b expected %b", i, ctl, 6'b111100); end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== 6'b000000) begin errors++; $display("FAIL mw_release: got %b expected %b", ctl, 6'b000000); end
    @(posedge clk); #1;
    idle();
    checks++;
    if (stall_count !== 16'd3) begin errors++; $display("FAIL mw_count: got %0d expected 3", stall_count); end
    @(negedge clk);
    checks++;
    if (ctl !== 6'b000000 || err !== 1'b0) begin
      errors++; $display("FAIL mw_back_run: got ctl=%b err=%b expected ctl=000000 err=0", ctl, err);
    end
  endtask

  task automatic test_mem_req_drop();
    @(posedge clk); #1;
    mem_req = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    mem_req = 1'b0; PCSrcD = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== 6'b000010) begin errors++; $display("FAIL drop_ctl: got %b expected %b", ctl, 6'b000010); end
    @(posedge clk); #1;
    idle();
    checks++;
    if (stall_count !== 16'd4) begin errors++; $display("FAIL drop_count: got %0d expected 4", stall_count); end
  endtask

  task automatic test_timeout();
    @(posedge clk); #1;
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (err4 !== 1'b0) begin errors++; $display("FAIL to_early_err[%0d]: got %b expected 0", i, err4); end
    end
    @(posedge clk); #1;
    checks++;
    if (err4 !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", err4); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL to_default_err: got %b expected 0", err); end
    idle();
    @(negedge clk);
    checks++;
    if (ctl4 !== 6'b111100) begin errors++; $display("FAIL to_error_ctl: got %b expected %b", ctl4, 6'b111100); end
    checks++;
    if (ctl !== 6'b000000) begin errors++; $display("FAIL to_default_ctl: got %b expected %b", ctl, 6'b000000); end
    @(posedge clk); #1;
    checks++;
    if (err4 !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", err4); end
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    checks++;
    if (err4 !== 1'b0 || ctl4 !== 6'b000000 || stall_count4 !== 16'd0) begin
      errors++; $display("FAIL to_async_reset: got err=%b ctl=%b cnt=%0d expected err=0 ctl=000000 cnt=0", err4, ctl4, stall_count4);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    MemtoRegE = 1'b1; RtE = 5'd12; RsD = 5'd12;
    @(negedge clk);
    checks++;
    if (ctl4 !== 6'b110001) begin errors++; $display("FAIL to_after_reset: got %b expected %b", ctl4, 6'b110001); end
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_clr_stats();
    test_branch();
    test_branch_lu();
    test_mem_wait();
    test_mem_req_drop();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
